// File: rtl/umix_mem_unit.sv
// -----------------------------------------------------------------------------
// umix_mem_unit
//
// Array memory responder for the UM-32 control unit. Owns all array storage:
// a flat single-port word RAM plus a descriptor table that maps a 32-bit
// array id (carried on mem_ctrl.address) onto a [base, base+size) RAM region.
// Array 0 is the program array and always occupies RAM [0, PROG_WORDS).
//
// Request kinds (decoded from mem_ctrl.mode, serviced only while idle):
//   00 read   : mem_data_out <= RAM[base[id] + offset]           (1 cycle)
//   01 write  : RAM[phys] <= data, mem_data_out <= old RAM[phys]  (1 cycle)
//   10 alloc  : pop a free id, bump-allocate .offset words, return the id
//   11 free   : invalidate id and return it to the free-id stack
//
// After init the unit spends WORDS cycles sweeping the RAM to zero and
// rebuilding the descriptor table and free-id stack; busy is high throughout
// and requests are dropped.
//
// Ports:
//   clk           clock
//   init          synchronous active-high reset; restarts the clear sweep
//   mem_ctrl      request bus (.data, .address = id, .offset, .mode)
//   mem_data_out  read data, pre-write data, or newly allocated id
//   busy          clear sweep in progress
//   fault         sticky error flag, cleared only by init
//
// Optional feature macro: UMIX_MEM_BOUNDS_CHECK_EN
//   When defined, reads/writes to an invalid id or with offset >= size are
//   rejected (read returns 0, write suppressed) and set fault. When undefined,
//   no check is made and the physical address simply wraps modulo WORDS.
// -----------------------------------------------------------------------------

package umix_mem_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic [31:0] offset;
        logic [1:0]  mode;
    } mem_in_bus_t;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_ALLOC = 2'b10;
    localparam logic [1:0] MODE_FREE  = 2'b11;

endpackage

module umix_mem_unit
    import umix_mem_pkg::*;
#(
    parameter int WORDS      = 4096,
    parameter int ARRAYS     = 64,
    parameter int PROG_WORDS = 1024
) (
    input  logic        clk,
    input  logic        init,
    input  mem_in_bus_t mem_ctrl,
    output logic [31:0] mem_data_out,
    output logic        busy,
    output logic        fault
);

    localparam int AW = $clog2(WORDS);
    localparam int IW = $clog2(ARRAYS);

    // One extra bit: the bump pointer and region ends may equal WORDS exactly.
    localparam logic [AW:0] PROG_SZ = (AW + 1)'(PROG_WORDS);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t state_q, state_d;

    // Backing word storage and descriptor table.
    logic [31:0]   ram     [WORDS];
    logic [AW:0]   base_q  [ARRAYS];
    logic [AW:0]   size_q  [ARRAYS];
    logic [ARRAYS-1:0] valid_q;

    // Free-id stack; sp_q counts live entries, top is stack_q[sp_q-1].
    logic [IW-1:0] stack_q [ARRAYS];
    logic [IW-1:0] sp_q;

    logic [AW:0]   bump_q;
    logic [AW-1:0] cnt_q;
    logic          fault_q;

    // Request decode
    logic          clearing;
    logic          idle;
    logic [IW-1:0] id;
    logic [AW:0]   phys_full;
    logic [AW-1:0] phys;
    logic [IW-1:0] new_id;
    logic [32:0]   alloc_end;
    logic          alloc_ok;
    logic          free_ok;
    logic          do_alloc;
    logic          do_free;
    logic          oob;
    logic          stack_fill;

    // RAM port
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;

    assign clearing  = (state_q == S_CLEAR);
    assign idle      = (state_q == S_IDLE);
    assign id        = mem_ctrl.address[IW-1:0];

    // Physical address wraps modulo WORDS; the carry bit is deliberately dropped.
    assign phys_full = base_q[id] + {1'b0, mem_ctrl.offset[AW-1:0]};
    assign phys      = phys_full[AW-1:0];

    // Region end computed at full 33-bit width so huge sizes cannot wrap past
    // the WORDS limit and appear to fit.
    assign alloc_end = {{(32 - AW){1'b0}}, bump_q} + {1'b0, mem_ctrl.offset};
    assign alloc_ok  = (sp_q != '0) && (alloc_end <= 33'(WORDS));
    assign new_id    = stack_q[sp_q - 1'b1];

    // Only a currently valid, non-program id may be freed; this also bounds the
    // stack depth to ARRAYS-1 since each push needs a distinct live id.
    assign free_ok   = (id != '0) && valid_q[id];

    assign do_alloc  = idle && (mem_ctrl.mode == MODE_ALLOC) && alloc_ok;
    assign do_free   = idle && (mem_ctrl.mode == MODE_FREE) && free_ok;

    // Ids 1..ARRAYS-1 are seeded during the first ARRAYS cycles of the sweep.
    assign stack_fill = (cnt_q != '0) && (cnt_q < AW'(ARRAYS));

`ifdef UMIX_MEM_BOUNDS_CHECK_EN
    logic [31:0] size_ext;
    assign size_ext = {{(31 - AW){1'b0}}, size_q[id]};
    assign oob      = !valid_q[id] || (mem_ctrl.offset >= size_ext);
`else
    logic [AW:0] unused_size;
    assign unused_size = size_q[id];
    assign oob         = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_ctrl.address[31:IW], phys_full[AW]};

    // RAM is shared between the zeroing sweep and write requests.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = phys;
        ram_wdata = mem_ctrl.data;
        if (clearing) begin
            ram_we    = !init;
            ram_addr  = cnt_q;
            ram_wdata = '0;
        end else if (idle && (mem_ctrl.mode == MODE_WRITE) && !oob) begin
            ram_we    = !init;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
    end

    // State machine
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy = 1'b1;
                if (cnt_q == AW'(WORDS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                busy = 1'b0;
            end
            default: begin
                state_d = S_CLEAR;
                busy    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Control state: sweep counter, valid bits, stack pointer, bump, outputs.
    always_ff @(posedge clk) begin
        if (init) begin
            cnt_q        <= '0;
            valid_q      <= '0;
            sp_q         <= '0;
            bump_q       <= PROG_SZ;
            fault_q      <= 1'b0;
            mem_data_out <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q   <= cnt_q + 1'b1;
                    valid_q <= {{(ARRAYS - 1){1'b0}}, 1'b1};
                    bump_q  <= PROG_SZ;
                    if (stack_fill) begin
                        sp_q <= cnt_q[IW-1:0];
                    end
                end
                S_IDLE: begin
                    case (mem_ctrl.mode)
                        MODE_READ, MODE_WRITE: begin
                            // Write returns the word it overwrites.
                            mem_data_out <= oob ? '0 : ram[phys];
                            if (oob) begin
                                fault_q <= 1'b1;
                            end
                        end
                        MODE_ALLOC: begin
                            if (alloc_ok) begin
                                mem_data_out    <= {{(32 - IW){1'b0}}, new_id};
                                valid_q[new_id] <= 1'b1;
                                sp_q            <= sp_q - 1'b1;
                                bump_q          <= alloc_end[AW:0];
                            end else begin
                                mem_data_out <= '0;
                                fault_q      <= 1'b1;
                            end
                        end
                        MODE_FREE: begin
                            if (free_ok) begin
                                valid_q[id] <= 1'b0;
                                sp_q        <= sp_q + 1'b1;
                            end else begin
                                fault_q <= 1'b1;
                            end
                        end
                        default: begin
                            fault_q <= fault_q;
                        end
                    endcase
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Descriptor and stack contents carry no reset; the sweep rebuilds them.
    // Ids are seeded highest first so that the lowest id ends up on top and
    // allocation hands out 1, 2, 3, ... after a sweep.
    always_ff @(posedge clk) begin
        if (!init) begin
            if (clearing) begin
                base_q[0] <= '0;
                size_q[0] <= PROG_SZ;
                if (stack_fill) begin
                    stack_q[cnt_q[IW-1:0] - 1'b1] <= IW'(0) - cnt_q[IW-1:0];
                end
            end else if (do_alloc) begin
                base_q[new_id] <= bump_q;
                size_q[new_id] <= mem_ctrl.offset[AW:0];
            end else if (do_free) begin
                stack_q[sp_q] <= id;
            end
        end
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_umix_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_umix_mem_unit
//
// Directed bench for umix_mem_unit. The driver issues one request per cycle
// and queues the response it expects at a given cycle; an independent monitor
// compares mem_data_out / fault / busy whenever an expectation falls due.
// -----------------------------------------------------------------------------

module tb_umix_mem_unit;
    import umix_mem_pkg::*;

    localparam int WORDS      = 4096;
    localparam int ARRAYS     = 64;
    localparam int PROG_WORDS = 1024;

`ifdef UMIX_MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        init = 1'b0;
    mem_in_bus_t mem_ctrl = '0;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    umix_mem_unit #(
        .WORDS      (WORDS),
        .ARRAYS     (ARRAYS),
        .PROG_WORDS (PROG_WORDS)
    ) dut (
        .clk          (clk),
        .init         (init),
        .mem_ctrl     (mem_ctrl),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .fault        (fault)
    );

    typedef struct {
        string       name;
        int          at;
        bit          cd;
        logic [31:0] d;
        bit          cf;
        logic        f;
        bit          cb;
        logic        b;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   eot    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation due at this cycle is compared and retired.
    always @(posedge clk) begin : monitor
        exp_t e;
        int   idx;
        #1;
        idx = 0;
        while (idx < sbq.size()) begin
            if (sbq[idx].at <= cyc) begin
                e = sbq[idx];
                sbq.delete(idx);
                if (e.at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: response slot cycle %0d missed, now %0d", e.name, e.at, cyc);
                end else begin
                    if (e.cd) begin
                        checks++;
                        if (mem_data_out !== e.d) begin
                            errors++;
                            $display("FAIL %s: mem_data_out=%h expected %h", e.name, mem_data_out, e.d);
                        end
                    end
                    if (e.cf) begin
                        checks++;
                        if (fault !== e.f) begin
                            errors++;
                            $display("FAIL %s: fault=%b expected %b", e.name, fault, e.f);
                        end
                    end
                    if (e.cb) begin
                        checks++;
                        if (busy !== e.b) begin
                            errors++;
                            $display("FAIL %s: busy=%b expected %b", e.name, busy, e.b);
                        end
                    end
                end
            end else begin
                idx++;
            end
        end
        if (eot && sbq.size() > 0) begin
            foreach (sbq[i]) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never checked", sbq[i].name, sbq[i].at);
            end
            sbq.delete();
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push(input string name, input int at,
                        input bit cd, input logic [31:0] d,
                        input bit cf, input logic f,
                        input bit cb, input logic b);
        exp_t e;
        e.name = name; e.at = at;
        e.cd = cd; e.d = d; e.cf = cf; e.f = f; e.cb = cb; e.b = b;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_ctrl = '0;
        end
    endtask

    task automatic issue(input logic [1:0] mode, input int id, input logic [31:0] off,
                         input logic [31:0] data, input string name,
                         input logic [31:0] d, input logic f, input logic b);
        @(negedge clk);
        mem_ctrl.mode    = mode;
        mem_ctrl.address = 32'(id);
        mem_ctrl.offset  = off;
        mem_ctrl.data    = data;
        push(name, cyc + 1, 1'b1, d, 1'b1, f, 1'b1, b);
    endtask

    task automatic rd(input int id, input int off, input string name,
                      input logic [31:0] d, input logic f);
        issue(MODE_READ, id, 32'(off), 32'h0, name, d, f, 1'b0);
    endtask

    task automatic wr(input int id, input int off, input logic [31:0] data,
                      input string name, input logic [31:0] d, input logic f);
        issue(MODE_WRITE, id, 32'(off), data, name, d, f, 1'b0);
    endtask

    task automatic al(input int size, input string name, input logic [31:0] d, input logic f);
        issue(MODE_ALLOC, 0, 32'(size), 32'h0, name, d, f, 1'b0);
    endtask

    task automatic fr(input int id, input string name, input logic [31:0] d, input logic f);
        issue(MODE_FREE, id, 32'h0, 32'h0, name, d, f, 1'b0);
    endtask

    // Pulse init for one cycle. Reset values are checked right after the
    // init edge; optionally the exact end of the WORDS-cycle sweep too.
    task automatic start_init(input bit with_busy, input string name);
        int k;
        @(negedge clk);
        init     = 1'b1;
        mem_ctrl = '0;
        k        = cyc;
        push({name, "_reset"}, k + 1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        init = 1'b0;
        if (with_busy) begin
            push({name, "_busy_last"}, k + WORDS, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            push({name, "_busy_done"}, k + WORDS + 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        // Power-up sweep
        start_init(1'b1, "sweep1");
        idle(WORDS + 2);

        // Program array reads after the sweep, and a seeded word
        rd(0, 0,    "rd0_0",    32'h0, 1'b0);
        rd(0, 1,    "rd0_1",    32'h0, 1'b0);
        rd(0, 511,  "rd0_511",  32'h0, 1'b0);
        rd(0, 1023, "rd0_1023", 32'h0, 1'b0);
        wr(0, 5, 32'hA5A5A5A5, "wr0_5", 32'h0, 1'b0);
        rd(0, 5, "rd0_5", 32'hA5A5A5A5, 1'b0);

        // Alloc and index
        al(5, "alloc5_id1", 32'd1, 1'b0);
        wr(1, 4, 32'hDEADBEEF, "wr1_4", 32'h0, 1'b0);
        rd(1, 4, "rd1_4", 32'hDEADBEEF, 1'b0);
        rd(1, 3, "rd1_3", 32'h0, 1'b0);
        wr(1, 4, 32'h11111111, "wr1_4_rbw", 32'hDEADBEEF, 1'b0);
        rd(1, 4, "rd1_4_new", 32'h11111111, 1'b0);

        // Id recycling and double free
        al(3, "alloc_id2", 32'd2, 1'b0);
        fr(1, "free1_hold", 32'd2, 1'b0);
        al(1, "realloc_id1", 32'd1, 1'b0);
        fr(1, "free1_again", 32'd1, 1'b0);
        fr(1, "double_free", 32'd1, 1'b1);
        al(0, "after_dfree_id1", 32'd1, 1'b1);
        al(0, "after_dfree_id3", 32'd3, 1'b1);

        // Reset mid-traffic: storage, descriptors and fault all cleared
        start_init(1'b1, "reinit");
        idle(WORDS + 2);
        rd(0, 5, "rd0_5_swept", 32'h0, 1'b0);
        al(5, "post_reset_id1", 32'd1, 1'b0);
        rd(1, 4, "rd1_4_swept", 32'h0, 1'b0);

        // Bounds: write one past a 2-word array, observe via the next region
        al(2, "alloc2_id2", 32'd2, 1'b0);
        wr(2, 2, 32'd7, "wr_oob", 32'h0, BC);
        al(1, "alloc1_id3", 32'd3, BC);
        rd(3, 0, "rd_spill", BC ? 32'h0 : 32'd7, BC);

        // Fill RAM exactly, zero-size at the limit, then one word too many
        al(WORDS - 1032, "alloc_fill_id4", 32'd4, BC);
        al(0, "alloc0_at_limit", 32'd5, BC);
        al(1, "alloc_overflow", 32'h0, 1'b1);

        // Free-id exhaustion
        start_init(1'b1, "exhaust");
        idle(WORDS + 2);
        for (int i = 1; i < ARRAYS; i++) begin
            al(0, $sformatf("alloc0_id%0d", i), 32'(i), 1'b0);
        end
        al(0, "alloc_no_id", 32'h0, 1'b1);

        // Init mid-sweep, and requests dropped while busy
        start_init(1'b0, "midsweep_a");
        idle(99);
        start_init(1'b1, "midsweep_b");
        idle(50);
        issue(MODE_WRITE, 0, 32'd7, 32'd5, "busy_wr_drop", 32'h0, 1'b0, 1'b1);
        issue(MODE_ALLOC, 0, 32'd5, 32'h0, "busy_al_drop", 32'h0, 1'b0, 1'b1);
        idle(WORDS);
        rd(0, 7, "rd0_7_nodrop", 32'h0, 1'b0);
        al(WORDS - PROG_WORDS + 1, "alloc_too_big", 32'h0, 1'b1);
        al(1, "alloc_after_fail", 32'd1, 1'b1);

        // Freeing the program array is rejected and must not push id 0
        start_init(1'b1, "free0");
        idle(WORDS + 2);
        fr(0, "free_id0", 32'h0, 1'b1);
        al(4, "alloc_after_free0", 32'd1, 1'b1);

        idle(3);
        eot = 1'b1;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
